pixel_reorder_buffer: RTL and testbench



---
 rtl/pixel_reorder_buffer.sv | 173 +++++++++++++++++
 tb/tb_pixel_reorder_buffer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_reorder_buffer.sv
// Multi-channel raster reorder buffer: engines deposit pixels into a DEPTH-slot window, emitted strictly in raster order.
// Optional head-of-line timeout with fill pixel and skip_o port: define PRB_TIMEOUT_EN.
module pixel_reorder_buffer #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned RBG_SIZE      = 24,
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned SCREEN_WIDTH  = 640,
  parameter int unsigned SCREEN_HEIGHT = 480,
  parameter int unsigned CNT_W         = $clog2(DEPTH + 1)
`ifdef PRB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT       = 1024
`endif
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            valid_i,
  output logic [NUM_CH-1:0]            ready_o,
  input  logic [NUM_CH*RBG_SIZE-1:0]   colour_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] xpixel_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ypixel_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [RBG_SIZE-1:0]          colour_o,
  output logic [DATA_WIDTH-1:0]        xpixel_o,
  output logic [DATA_WIDTH-1:0]        ypixel_o,
  output logic [CNT_W-1:0]             occupancy,
  output logic                         full_queue,
  output logic                         frame_done,
  output logic                         drop_err
`ifdef PRB_TIMEOUT_EN
  ,
  output logic                         skip_o
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW = DATA_WIDTH + 2;
  localparam logic [DATA_WIDTH-1:0] LAST_X = DATA_WIDTH'(SCREEN_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] LAST_Y = DATA_WIDTH'(SCREEN_HEIGHT - 1);

  logic [DATA_WIDTH-1:0] exp_x;
  logic [DATA_WIDTH-1:0] exp_y;
  logic [AW-1:0]         head;
  logic [DEPTH-1:0]      occ;
  logic [RBG_SIZE-1:0]   colour_mem [DEPTH];

  logic [DATA_WIDTH-1:0] x_c    [NUM_CH];
  logic [DATA_WIDTH-1:0] y_c    [NUM_CH];
  logic [OW-1:0]         off_c  [NUM_CH];
  logic [AW-1:0]         slot_c [NUM_CH];
  logic [NUM_CH-1:0]     win_c;
  logic [NUM_CH-1:0]     lose_c;
  logic [NUM_CH-1:0]     drop_c;
  logic [NUM_CH-1:0]     wr_c;
  logic [CNT_W-1:0]      nwr_c;
  logic [CNT_W-1:0]      occ_nxt_c;
  logic                  skip_c;
  logic                  pop_c;
  logic                  pop_real_c;

  // Classify every channel against the pre-pop window and resolve same-slot collisions.
  always_comb begin
    win_c  = '0;
    lose_c = '0;
    drop_c = '0;
    wr_c   = '0;
    nwr_c  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      x_c[c]    = xpixel_i[c*DATA_WIDTH +: DATA_WIDTH];
      y_c[c]    = ypixel_i[c*DATA_WIDTH +: DATA_WIDTH];
      off_c[c]  = '0;
      slot_c[c] = '0;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (valid_i[c]) begin
        if (x_c[c] >= DATA_WIDTH'(SCREEN_WIDTH) || y_c[c] >= DATA_WIDTH'(SCREEN_HEIGHT)) begin
          drop_c[c] = 1'b1;
        end else if (y_c[c] == exp_y && x_c[c] >= exp_x) begin
          off_c[c] = OW'(x_c[c]) - OW'(exp_x);
          win_c[c] = off_c[c] < OW'(DEPTH);
        end else if ((exp_y != LAST_Y && y_c[c] == exp_y + DATA_WIDTH'(1)) ||
                     (exp_y == LAST_Y && y_c[c] == '0)) begin
          off_c[c] = OW'(x_c[c]) + OW'(SCREEN_WIDTH) - OW'(exp_x);
          win_c[c] = off_c[c] < OW'(DEPTH);
        end else if ((y_c[c] == exp_y && x_c[c] < exp_x) || y_c[c] < exp_y) begin
          // wrap case (exp_y last, y==0) was caught above, so this is already emitted
          drop_c[c] = 1'b1;
        end
        slot_c[c] = head + off_c[c][AW-1:0];
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      for (int j = 0; j < c; j++) begin
        if (win_c[j] && win_c[c] && slot_c[j] == slot_c[c]) lose_c[c] = 1'b1;
      end
      if (win_c[c] && !lose_c[c]) begin
        if (occ[slot_c[c]] || (skip_c && off_c[c] == '0)) drop_c[c] = 1'b1;
        else                                              wr_c[c]   = 1'b1;
      end
      nwr_c = nwr_c + CNT_W'(wr_c[c]);
    end
  end

  assign ready_o    = reset ? '0 : (drop_c | wr_c);
  assign valid_o    = !reset && (occ[head] || skip_c);
  assign colour_o   = skip_c ? {RBG_SIZE{1'b1}} : colour_mem[head];
  assign xpixel_o   = exp_x;
  assign ypixel_o   = exp_y;
  assign pop_c      = valid_o && ready_i;
  assign pop_real_c = pop_c && occ[head];
  assign occ_nxt_c  = occupancy + nwr_c - CNT_W'(pop_real_c);

  // Window state, raster position and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ        <= '0;
      head       <= '0;
      exp_x      <= '0;
      exp_y      <= '0;
      occupancy  <= '0;
      full_queue <= 1'b0;
      frame_done <= 1'b0;
      drop_err   <= 1'b0;
    end else begin
      drop_err   <= |drop_c;
      frame_done <= pop_c && exp_x == LAST_X && exp_y == LAST_Y;
      occupancy  <= occ_nxt_c;
      full_queue <= occ_nxt_c == CNT_W'(DEPTH);
      if (pop_c) begin
        occ[head] <= 1'b0;
        head      <= head + AW'(1);
        if (exp_x == LAST_X) begin
          exp_x <= '0;
          exp_y <= (exp_y == LAST_Y) ? '0 : exp_y + DATA_WIDTH'(1);
        end else begin
          exp_x <= exp_x + DATA_WIDTH'(1);
        end
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_c[c]) occ[slot_c[c]] <= 1'b1;
      end
    end
  end

  // Pixel payload storage; validity is tracked by occ, so no reset needed.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_c[c] && !reset) colour_mem[slot_c[c]] <= colour_i[c*RBG_SIZE +: RBG_SIZE];
    end
  end

`ifdef PRB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;

  // Head-of-line stall timer; saturates at TIMEOUT until the fill pixel is popped.
  always_ff @(posedge clk) begin
    if (reset || pop_c) begin
      tcnt <= '0;
    end else if (!occ[head] && occupancy != '0 && tcnt != TW'(TIMEOUT)) begin
      tcnt <= tcnt + TW'(1);
    end
  end

  assign skip_c = (tcnt == TW'(TIMEOUT));
  assign skip_o = skip_c && !reset;
`else
  assign skip_c = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_reorder_buffer.sv
// Randomised scoreboard bench for pixel_reorder_buffer on a small screen so frame wrap is reached.
module tb_pixel_reorder_buffer;

  localparam int DW     = 32;
  localparam int CW     = 24;
  localparam int NCH    = 4;
  localparam int DEPTH  = 16;
  localparam int W      = 32;
  localparam int H      = 4;
  localparam int N      = W * H;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int CYCLES = 4000;

  logic                clk = 1'b0;
  logic                reset;
  logic [NCH-1:0]      valid_i;
  logic [NCH-1:0]      ready_o;
  logic [NCH*CW-1:0]   colour_i;
  logic [NCH*DW-1:0]   xpixel_i;
  logic [NCH*DW-1:0]   ypixel_i;
  logic                valid_o;
  logic                ready_i;
  logic [CW-1:0]       colour_o;
  logic [DW-1:0]       xpixel_o;
  logic [DW-1:0]       ypixel_o;
  logic [CNT_W-1:0]    occupancy;
  logic                full_queue;
  logic                frame_done;
  logic                drop_err;
`ifdef PRB_TIMEOUT_EN
  logic                skip_o;
`endif

  pixel_reorder_buffer #(
    .DATA_WIDTH(DW), .RBG_SIZE(CW), .NUM_CH(NCH), .DEPTH(DEPTH),
    .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .CNT_W(CNT_W)
`ifdef PRB_TIMEOUT_EN
    , .TIMEOUT(60000)
`endif
  ) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
    .colour_i(colour_i), .xpixel_i(xpixel_i), .ypixel_i(ypixel_i),
    .valid_o(valid_o), .ready_i(ready_i), .colour_o(colour_o),
    .xpixel_o(xpixel_o), .ypixel_o(ypixel_o), .occupancy(occupancy),
    .full_queue(full_queue), .frame_done(frame_done), .drop_err(drop_err)
`ifdef PRB_TIMEOUT_EN
    , .skip_o(skip_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int col; } pix_t;

  pix_t exp_q[$];
  int   model_col [int];
  int   e_abs;
  int   next_push;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vx   [NCH];
  int   vy   [NCH];
  int   vcol [NCH];
  logic exp_valid, exp_full, exp_drop, exp_frame;
  int   exp_occ;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    model_col.delete();
    exp_q.delete();
    e_abs     = 0;
    next_push = 0;
    exp_valid = 1'b0;
    exp_full  = 1'b0;
    exp_drop  = 1'b0;
    exp_frame = 1'b0;
    exp_occ   = 0;
  endtask

  // Raster-distance reference: what each engine should see and what happens at the coming edge.
  task automatic model_step();
    int q, ey, p, d;
    bit claimed [DEPTH];
    bit pop;
    int wr_key[$];
    int wr_col[$];
    logic [NCH-1:0] rdy;
    pix_t px;
    rdy = '0;
    if (reset) begin
      for (int c = 0; c < NCH; c++) check("ready_in_reset", 64'(ready_o[c]), 64'(0));
      model_reset();
      return;
    end
    exp_drop = 1'b0;
    q  = e_abs % N;
    ey = q / W;
    for (int c = 0; c < NCH; c++) begin
      if (valid_i[c]) begin
        if (vx[c] >= W || vy[c] >= H) begin
          rdy[c] = 1'b1; exp_drop = 1'b1;
        end else begin
          p = vy[c] * W + vx[c];
          d = (p - q + N) % N;
          if (d < DEPTH) begin
            if (!claimed[d]) begin
              claimed[d] = 1'b1;
              rdy[c]     = 1'b1;
              if (model_col.exists(e_abs + d)) exp_drop = 1'b1;
              else begin
                wr_key.push_back(e_abs + d);
                wr_col.push_back(vcol[c]);
              end
            end
          end else if (p < q && !(ey == H - 1 && vy[c] == 0)) begin
            rdy[c] = 1'b1; exp_drop = 1'b1;
          end
        end
      end
    end
    for (int c = 0; c < NCH; c++) check("ready_o", 64'(ready_o[c]), 64'(rdy[c]));
    pop = model_col.exists(e_abs) && ready_i;
    foreach (wr_key[i]) model_col[wr_key[i]] = wr_col[i];
    while (model_col.exists(next_push)) begin
      px.x   = (next_push % N) % W;
      px.y   = (next_push % N) / W;
      px.col = model_col[next_push];
      exp_q.push_back(px);
      next_push++;
    end
    exp_frame = pop && q == N - 1;
    if (pop) begin
      model_col.delete(e_abs);
      e_abs++;
    end
    exp_valid = model_col.exists(e_abs);
    exp_occ   = model_col.num();
    exp_full  = exp_occ == DEPTH;
  endtask

  task automatic check_state();
    check("valid_o",    64'(valid_o),    64'(exp_valid));
    check("occupancy",  64'(occupancy),  64'(exp_occ));
    check("full_queue", 64'(full_queue), 64'(exp_full));
    check("drop_err",   64'(drop_err),   64'(exp_drop));
    check("frame_done", 64'(frame_done), 64'(exp_frame));
  endtask

  task automatic drive(input bit rst, input int rdy_pct);
    int q, o, pl;
    reset   = rst;
    ready_i = ($urandom_range(0, 99) < rdy_pct);
    q = e_abs % N;
    for (int c = 0; c < NCH; c++) begin
      valid_i[c] = ($urandom_range(0, 9) < 7);
      o  = int'($urandom_range(0, DEPTH + 11)) - 6;
      pl = ((q + o) % N + N) % N;
      vx[c]   = pl % W;
      vy[c]   = pl / W;
      vcol[c] = int'($urandom() & 32'h00FF_FFFF);
      case ($urandom_range(0, 39))
        0: vx[c] = W + int'($urandom_range(0, 40));
        1: vy[c] = H + int'($urandom_range(0, 5));
        default: ;
      endcase
      colour_i[c*CW +: CW] = CW'(vcol[c]);
      xpixel_i[c*DW +: DW] = DW'(vx[c]);
      ypixel_i[c*DW +: DW] = DW'(vy[c]);
    end
  endtask

  // Monitor: every accepted output must be the next raster pixel in the scoreboard.
  initial begin
    pix_t px;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL out_unexpected: got x=%0d y=%0d, expected no output at %0t", xpixel_o, ypixel_o, $time);
        end else begin
          px = exp_q.pop_front();
          check("out_x",      64'(xpixel_o), 64'(px.x));
          check("out_y",      64'(ypixel_o), 64'(px.y));
          check("out_colour", 64'(colour_o), 64'(px.col));
        end
      end
    end
  end

  initial begin
    int pct;
    reset    = 1'b1;
    ready_i  = 1'b0;
    valid_i  = '1;
    colour_i = '0;
    xpixel_i = '0;
    ypixel_i = '0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < NCH; c++) check("ready_in_reset", 64'(ready_o[c]), 64'(0));
    check_state();
    pct = 90;
    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      if (cyc % 250 == 0) begin
        case ((cyc / 250) % 4)
          0: pct = 90;
          1: pct = 20;
          2: pct = 0;
          default: pct = 60;
        endcase
      end
      drive(cyc == 1520 || cyc == 2760, pct);
      #1;
      model_step();
      @(negedge clk);
      check_state();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
